// File: rtl/spi_enc_pkg.sv
// Shared definitions for the SPI encoder counter bank.
//   - spi_state_e   : SPI slave FSM states
//   - SPI_ADDR_W    : width of the byte pointer / start address
//   - CMD_CLEAR_BIT : command byte bit that requests clear-on-read
//   - MAX_CHANNELS  : upper bound on the number of counter channels
package spi_enc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } spi_state_e;

    localparam int SPI_ADDR_W    = 7;
    localparam int CMD_CLEAR_BIT = 7;
    localparam int MAX_CHANNELS  = 16;

endpackage

// File: rtl/quad_decoder.sv
// One quadrature channel: 2-FF input synchroniser, optional glitch filter,
// 4x decoder and wrapping up/down counter.
// Optional feature macro: SPI_ENC_FILTER_EN (3-sample agreement filter).
// Ports:
//   clk, rst_n   : system clock, async active-low reset
//   enc_a, enc_b : raw (asynchronous) encoder phases
//   clear        : zero the counter this cycle (wins over a count edge)
//   count        : current counter value
module quad_decoder #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enc_a,
    input  logic                   enc_b,
    input  logic                   clear,
    output logic [COUNT_WIDTH-1:0] count
);

    // Phase pairs are kept as {a, b}.
    logic [1:0]             s1_q, s1_d;
    logic [1:0]             s2_q, s2_d;
    logic [1:0]             prev_q, prev_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [1:0]             ab;
    logic [1:0]             pos_cur, pos_prev, step;
`ifdef SPI_ENC_FILTER_EN
    logic [1:0]             s3_q, s3_d;
    logic [1:0]             filt_q, filt_d;
`endif

    always_comb begin
        s1_d = {enc_a, enc_b};
        s2_d = s1_q;
`ifdef SPI_ENC_FILTER_EN
        // Window is the pin sampled on three consecutive edges (s1, s2, s3).
        // A pulse shorter than 3 clk never fills the window, and the filtered
        // value is used combinationally so only one clk of latency is added.
        s3_d = s2_q;
        for (int i = 0; i < 2; i++) begin
            filt_d[i] = ((s1_q[i] == s2_q[i]) && (s2_q[i] == s3_q[i])) ? s2_q[i] : filt_q[i];
        end
        ab = filt_d;
`else
        ab = s2_q;
`endif
        // Map the Gray sequence 00,01,11,10 onto positions 0..3; the
        // modulo-4 position difference gives +1, -1 or the illegal 2.
        pos_cur  = {ab[1], ab[1] ^ ab[0]};
        pos_prev = {prev_q[1], prev_q[1] ^ prev_q[0]};
        step     = pos_cur - pos_prev;
        // Always track the observed state so an illegal jump resynchronises.
        prev_d   = ab;
        count_d  = count_q;
        if (clear) begin
            count_d = '0;
        end else if (step == 2'd1) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end else if (step == 2'd3) begin
            count_d = count_q - COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= '0;
            s2_q    <= '0;
            prev_q  <= '0;
            count_q <= '0;
`ifdef SPI_ENC_FILTER_EN
            s3_q    <= '0;
            filt_q  <= '0;
`endif
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            prev_q  <= prev_d;
            count_q <= count_d;
`ifdef SPI_ENC_FILTER_EN
            s3_q    <= s3_d;
            filt_q  <= filt_d;
`endif
        end
    end

    assign count = count_q;

endmodule

// File: rtl/spi_encoder_bank.sv
// Bank of NUM_CHANNELS quadrature counters read through a mode-0 SPI slave.
// A transaction is a command byte ({CLEAR, start_addr[6:0]}) followed by any
// number of data bytes streamed little-endian from a snapshot taken at cs fall.
// Optional feature macro: SPI_ENC_FILTER_EN (enables the per-phase glitch
// filter inside quad_decoder).
// Ports:
//   clk, rst_n   : system clock, async active-low reset
//   enc_a, enc_b : encoder phases, one bit per channel (asynchronous)
//   cs, sck, mosi: SPI slave inputs (asynchronous, oversampled)
//   miso         : SPI data out, forced low while cs is high
// Handshake: none; SPI framing is recovered from synchronised edges, so sck
// high/low times and cs idle time must each be at least 4 clk.
module spi_encoder_bank #(
    parameter int NUM_CHANNELS = 2,
    parameter int COUNT_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CHANNELS-1:0] enc_a,
    input  logic [NUM_CHANNELS-1:0] enc_b,
    input  logic                    cs,
    input  logic                    sck,
    input  logic                    mosi,
    output logic                    miso
);
    import spi_enc_pkg::*;

    localparam int BPC    = COUNT_WIDTH / 8;
    localparam int TOTAL  = NUM_CHANNELS * BPC;
    localparam int SNAP_W = NUM_CHANNELS * COUNT_WIDTH;

    logic [SNAP_W-1:0]     counts;
    logic [SNAP_W-1:0]     snap_q, snap_d;
    // [0] first sync stage, [1] synchronised value, [2] previous value
    logic [2:0]            cs_sync_q, cs_sync_d;
    logic [2:0]            sck_sync_q, sck_sync_d;
    logic [1:0]            mosi_sync_q, mosi_sync_d;
    spi_state_e            state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [SPI_ADDR_W-1:0] rx_q, rx_d;
    logic [7:0]            tx_q, tx_d;
    logic [SPI_ADDR_W-1:0] ptr_q, ptr_d;
    logic                  clr_lat_q, clr_lat_d;
    logic                  clr_pulse_q, clr_pulse_d;

    logic                  cs_fall, cs_rise, sck_rise, sck_fall;
    logic                  bit_inc, rx_shift, cmd_done, byte_done, tx_shift, data_en;
    logic [7:0]            cmd_byte, rd_byte;
    logic [SPI_ADDR_W-1:0] rd_addr;

    genvar g;
    generate
        for (g = 0; g < NUM_CHANNELS; g++) begin : g_chan
            quad_decoder #(.COUNT_WIDTH(COUNT_WIDTH)) u_dec (
                .clk   (clk),
                .rst_n (rst_n),
                .enc_a (enc_a[g]),
                .enc_b (enc_b[g]),
                .clear (clr_pulse_q),
                .count (counts[g*COUNT_WIDTH +: COUNT_WIDTH])
            );
        end
    endgenerate

    always_comb begin
        cs_sync_d   = {cs_sync_q[1:0], cs};
        sck_sync_d  = {sck_sync_q[1:0], sck};
        mosi_sync_d = {mosi_sync_q[0], mosi};
    end

    assign cs_fall  =  cs_sync_q[2] & ~cs_sync_q[1];
    assign cs_rise  = ~cs_sync_q[2] &  cs_sync_q[1];
    assign sck_rise = ~sck_sync_q[2] &  sck_sync_q[1];
    assign sck_fall =  sck_sync_q[2] & ~sck_sync_q[1];

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (cs_fall)  state_d = ST_CMD;
                ST_CMD:  if (cmd_done) state_d = ST_DATA;
                default: ;
            endcase
        end
    end

    // FSM: outputs (datapath strobes)
    always_comb begin
        bit_inc   = 1'b0;
        rx_shift  = 1'b0;
        cmd_done  = 1'b0;
        byte_done = 1'b0;
        tx_shift  = 1'b0;
        data_en   = 1'b0;
        case (state_q)
            ST_CMD: begin
                bit_inc  = sck_rise & ~cs_rise;
                rx_shift = bit_inc;
                cmd_done = bit_inc & (bit_cnt_q == 3'd7);
            end
            ST_DATA: begin
                data_en   = 1'b1;
                bit_inc   = sck_rise & ~cs_rise;
                byte_done = bit_inc & (bit_cnt_q == 3'd7);
                // The fall that follows a byte's 8th rise has bit_cnt 0; it
                // must not shift, or the freshly loaded MSB would be lost.
                tx_shift  = sck_fall & ~cs_rise & (bit_cnt_q != 3'd0);
            end
            default: ;
        endcase
    end

    // Datapath
    always_comb begin
        cmd_byte = {rx_q, mosi_sync_q[1]};
        rd_addr  = cmd_done ? cmd_byte[SPI_ADDR_W-1:0] : ptr_q + 7'd1;
        rd_byte  = 8'h00;
        for (int i = 0; i < TOTAL; i++) begin
            if (rd_addr == SPI_ADDR_W'(i)) rd_byte = snap_q[i*8 +: 8];
        end

        // Counters are flops, so a count update in this cycle is not yet seen.
        snap_d      = cs_fall ? counts : snap_q;
        clr_pulse_d = cs_rise & clr_lat_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        ptr_d       = ptr_q;
        clr_lat_d   = clr_lat_q;

        if (cs_rise || cs_fall) begin
            bit_cnt_d = 3'd0;
            rx_d      = '0;
            tx_d      = 8'h00;
            clr_lat_d = 1'b0;
        end else begin
            if (bit_inc)  bit_cnt_d = bit_cnt_q + 3'd1;
            if (rx_shift) rx_d = cmd_byte[SPI_ADDR_W-1:0];
            if (cmd_done) begin
                ptr_d     = rd_addr;
                clr_lat_d = cmd_byte[CMD_CLEAR_BIT];
                tx_d      = rd_byte;
            end
            if (byte_done) begin
                ptr_d = rd_addr;
                tx_d  = rd_byte;
            end
            if (tx_shift) tx_d = {tx_q[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q   <= 3'b111;
            sck_sync_q  <= 3'b000;
            mosi_sync_q <= 2'b00;
            snap_q      <= '0;
            bit_cnt_q   <= 3'd0;
            rx_q        <= '0;
            tx_q        <= 8'h00;
            ptr_q       <= '0;
            clr_lat_q   <= 1'b0;
            clr_pulse_q <= 1'b0;
        end else begin
            cs_sync_q   <= cs_sync_d;
            sck_sync_q  <= sck_sync_d;
            mosi_sync_q <= mosi_sync_d;
            snap_q      <= snap_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            ptr_q       <= ptr_d;
            clr_lat_q   <= clr_lat_d;
            clr_pulse_q <= clr_pulse_d;
        end
    end

    // Gated with the raw pin so miso is low the instant cs deasserts.
    assign miso = data_en & tx_q[7] & ~cs;

endmodule
